// File: rtl/vlc_pkg.sv
// vlc_pkg: constants and shared types for the VLC packet buffer.
//   ADDR_W / DATA_W / DEPTH : geometry of the backing RAM (1024 x 8)
//   LVL_W                   : width of the fill level, holds DEPTH + 2
//   prio_e                  : which side of the single RAM port wins a conflict
package vlc_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LVL_W  = 11;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;
endpackage

// File: rtl/ram_1024x8.sv
// ram_1024x8: single-port synchronous RAM, one access per cycle.
//   clk  : clock
//   we   : write strobe; when low the cycle is a read
//   addr : word address
//   din  : write data
//   dout : read data, registered (valid the cycle after a read)
module ram_1024x8 #(
  parameter int AW = vlc_pkg::ADDR_W,
  parameter int DW = vlc_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    else    dout      <= mem[addr];
  end
endmodule

// File: rtl/vlc_buf_ctrl.sv
// vlc_buf_ctrl: circular byte buffer over a single-port RAM between the VLC
// RX deserializer (writer) and the TX/host framer (reader).
//   clk, rst_n         : clock, synchronous active-low reset
//   flush              : synchronous clear of all buffer state
//   wr_valid/ready/data: write stream; wr_ready is the RAM-port grant
//   rd_valid/ready/data: read stream from a 2-entry skid hiding RAM latency
//   level              : bytes in RAM + in-flight read + skid occupancy
//   empty / full       : level == 0 / RAM holds DEPTH unread-issued bytes
module vlc_buf_ctrl #(
  parameter int ADDR_W = vlc_pkg::ADDR_W,
  parameter int DATA_W = vlc_pkg::DATA_W,
  parameter int LVL_W  = vlc_pkg::LVL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level,
  output logic              empty,
  output logic              full
);
  import vlc_pkg::*;

  logic [ADDR_W-1:0]          wptr, rptr;
  logic [ADDR_W:0]            mem_cnt;
  logic                       inflight;
  logic [1:0]                 occ, occ_n;
  prio_e                      prio;
  logic [1:0][DATA_W-1:0]     sk, sk_n;
  logic [DATA_W-1:0]          ram_dout;

  logic       clr, rd_fire, wr_cand, rd_cand, wr_elig, wr_go, rd_go, conflict;
  logic [2:0] pend;

  assign clr      = !rst_n || flush;
  assign rd_valid = occ != 2'd0;
  assign rd_data  = sk[0];
  assign rd_fire  = rd_valid && rd_ready;

  // Skid slots that will be taken once this cycle's pop and landing settle;
  // a new read may only be issued if its byte is sure to have a slot.
  // rd_fire implies occ >= 1, so this never underflows.
  assign pend = {1'b0, occ} + {2'b00, inflight} - {2'b00, rd_fire};

  // mem_cnt never exceeds DEPTH, so its MSB alone marks a full RAM.
  assign full     = mem_cnt[ADDR_W];
  assign wr_cand  = !mem_cnt[ADDR_W];
  assign rd_cand  = (mem_cnt != '0) && (pend < 3'd2);
  assign wr_elig  = rst_n && !flush && wr_cand;
  assign wr_ready = wr_elig && (!rd_cand || prio == PRIO_WR);
  assign wr_go    = wr_valid && wr_ready;
  assign rd_go    = rd_cand && !wr_go;
  assign conflict = wr_valid && wr_elig && rd_cand;

  assign level = LVL_W'(mem_cnt) + LVL_W'(inflight) + LVL_W'(occ);
  assign empty = level == '0;

  ram_1024x8 #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
    .clk  (clk),
    .we   (wr_go),
    .addr (wr_go ? wptr : rptr),
    .din  (wr_data),
    .dout (ram_dout)
  );

  // Skid: pop shifts the head out first, then the returning RAM byte lands
  // in the first free slot. The issue rule guarantees a slot exists.
  always_comb begin
    sk_n  = sk;
    occ_n = occ;
    if (rd_fire) begin
      sk_n[0] = sk[1];
      occ_n   = occ - 2'd1;
    end
    if (inflight) begin
      sk_n[occ_n[0]] = ram_dout;
      occ_n          = occ_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      occ      <= '0;
      sk       <= '0;
      prio     <= PRIO_WR;
    end else begin
      if (wr_go) wptr <= wptr + ADDR_W'(1);
      if (rd_go) rptr <= rptr + ADDR_W'(1);
      if (wr_go)      mem_cnt <= mem_cnt + (ADDR_W+1)'(1);
      else if (rd_go) mem_cnt <= mem_cnt - (ADDR_W+1)'(1);
      inflight <= rd_go;
      sk       <= sk_n;
      occ      <= occ_n;
      if (conflict) prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end
  end
endmodule

// File: tb/tb_vlc_buf_ctrl.sv
// tb_vlc_buf_ctrl: directed stimulus against a queue-level model of the
// buffer (RAM contents, in-flight read, skid), checked every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_vlc_buf_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready, rd_valid, empty, full;
  logic [7:0]  rd_data;
  logic [10:0] level;

  int n_cmp = 0, n_bad = 0;
  bit mdl_on = 1'b0;

  always #5 clk = ~clk;

  vlc_buf_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .empty(empty), .full(full)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes waiting in RAM, the byte on its way out of RAM, and the
  // bytes sitting in the output skid, as plain queues.
  byte unsigned q_mem[$], q_fly[$], q_skid[$];
  bit m_prio = 1'b0;

  always @(negedge clk) if (mdl_on) begin
    int occ, fly, mc;
    bit fire, rc, welig, wrdy, wgo, rgo;
    occ   = q_skid.size();
    fly   = q_fly.size();
    mc    = q_mem.size();
    fire  = (occ > 0) && rd_ready;
    rc    = (mc > 0) && (occ + fly - int'(fire) < 2);
    welig = rst_n && !flush && (mc < DEPTH);
    wrdy  = welig && (!rc || !m_prio);
    chk("wr_ready", wr_ready, wrdy);
    chk("rd_valid", rd_valid, occ > 0);
    chk("level", level, mc + fly + occ);
    chk("empty", empty, (mc + fly + occ) == 0);
    chk("full", full, mc == DEPTH);
    if (occ > 0) chk("rd_data", rd_data, q_skid[0]);
    wgo = wr_valid && wrdy;
    rgo = rc && !wgo;
    if (!rst_n || flush) begin
      q_mem.delete(); q_fly.delete(); q_skid.delete();
      m_prio = 1'b0;
    end else begin
      if (fire) void'(q_skid.pop_front());
      if (fly > 0) q_skid.push_back(q_fly.pop_front());
      if (wgo) q_mem.push_back(wr_data);
      if (rgo) q_fly.push_back(q_mem.pop_front());
      if (wr_valid && welig && rc) m_prio = !m_prio;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit g = 1'b0;
    wr_valid = 1'b1; wr_data = b;
    for (int n = 0; n < 64 && !g; n++) begin
      #1 g = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    chk("push_grant", g, 1);
  endtask

  task automatic wait_byte(input string nm, input logic [7:0] exp);
    bit seen = 1'b0;
    logic [7:0] got = 8'h00;
    for (int n = 0; n < 10 && !seen; n++) begin
      #1;
      if (rd_valid) begin seen = 1'b1; got = rd_data; end
      tick();
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_data"}, got, exp);
  endtask

  logic [7:0] e3 [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int cnt, k, bad, j, x;
    bit g;
    // reset, with a write offered that must not be granted
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'hEE;
    tick(); mdl_on = 1'b1;
    tick();
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst_n = 1'b1; wr_valid = 1'b0;
    tick();

    // three bytes in, then read out back to back
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    #1;
    chk("t1_level", level, 3);
    chk("t1_empty", empty, 0);
    repeat (4) tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_rd_valid", rd_valid, 1);
      chk("t1_rd_data", rd_data, e3[i]);
      tick();
    end
    #1 chk("t1_empty_after", empty, 1);
    rd_ready = 1'b0;
    tick();

    // fill to full with the reader stalled; skid absorbs two extra bytes
    wr_valid = 1'b1; cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      wr_data = cnt[7:0];
      #1 g = wr_ready;
      tick();
      if (g) cnt++;
    end
    #1;
    chk("t2_accepted", cnt, 1026);
    chk("t2_level", level, 1026);
    chk("t2_full", full, 1);
    chk("t2_wr_ready", wr_ready, 0);
    wr_valid = 1'b0; rd_ready = 1'b1; k = 0; bad = 0;
    for (int c = 0; c < 1100; c++) begin
      #1;
      if (rd_valid) begin
        if (rd_data !== k[7:0]) bad++;
        k++;
      end
      tick();
    end
    chk("t2_drained", k, 1026);
    chk("t2_order_errs", bad, 0);
    chk("t2_empty", empty, 1);

    // both sides saturated: grants alternate starting with the writer
    rd_ready = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 100; i++) push_byte(8'(i));
    repeat (4) tick();
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 208; i++) begin
      wr_data = 8'(8'hC0 + i);
      if (i < 8) #1 chk("t3_grant_alt", wr_ready, (i % 2) == 0);
      tick();
    end
    wr_valid = 1'b0;
    repeat (400) tick();
    #1 chk("t3_empty", empty, 1);

    // pointer wrap: stream 1030 bytes from cleared pointers through 1023->0
    flush = 1'b1; tick(); flush = 1'b0;
    j = 0; k = 0; bad = 0; rd_ready = 1'b1;
    for (int c = 0; c < 2400 && k < 1030; c++) begin
      x = j * 7 + 3;
      wr_data = x[7:0];
      wr_valid = j < 1030;
      #1;
      g = wr_ready && wr_valid;
      if (rd_valid) begin
        x = k * 7 + 3;
        if (rd_data !== x[7:0]) bad++;
        k++;
      end
      tick();
      if (g) j++;
    end
    wr_valid = 1'b0;
    chk("t4_count", k, 1030);
    chk("t4_order_errs", bad, 0);

    // flush while a read is in flight: stale byte discarded
    rd_ready = 1'b0;
    tick();
    push_byte(8'h77);          // read of 0x77 issues this cycle
    tick();                    // read now in flight
    flush = 1'b1;
    #1 chk("t5_wr_ready_flush", wr_ready, 0);
    tick(); flush = 1'b0;
    #1;
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_level", level, 0);
    tick();
    #1;
    chk("t5_rd_valid2", rd_valid, 0);
    chk("t5_empty", empty, 1);
    push_byte(8'hA5);
    rd_ready = 1'b1;
    wait_byte("t5", 8'hA5);

    // reset mid-stream with the reader toggling
    wr_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      wr_data = 8'(c + 8'h80);
      rd_ready = c[0];
      tick();
    end
    rst_n = 1'b0;
    #1 chk("t6_wr_ready_rst", wr_ready, 0);
    tick();
    #1;
    chk("t6_level", level, 0);
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    rst_n = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    tick();
    push_byte(8'h5A);
    rd_ready = 1'b1;
    wait_byte("t6", 8'h5A);
    repeat (3) tick();
    #1 chk("t6_empty_end", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
